// File: rtl/axi_wr_slave_mem_if.sv
// AXI4 write-channel bundle (AW/W/B) between a write master
// and the axi_wr_slave_mem responder.
interface axi_wr_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output awid, awaddr, awlen, awsize,
    output awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize,
    input  awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_wr_slave_mem.sv
// AXI4 write responder: one burst at a time into a small
// byte-strobed word memory, one B response per burst.
module axi_wr_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_WORDS  = 16
) (
  input  logic                         sig_clock,
  input  logic                         sig_reset,
  axi_wr_slave_mem_if.slave            bus,
  input  logic [$clog2(MEM_WORDS)-1:0] dbg_idx,
  output logic [DATA_WIDTH-1:0]        dbg_data
);
  localparam int LSB = $clog2(STRB_WIDTH);
  localparam int IW  = ADDR_WIDTH - LSB;
  localparam int MW  = $clog2(MEM_WORDS);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [ID_WIDTH-1:0]   id_q;
  logic [IW-1:0]         idx_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic [1:0]            burst_q;
  logic                  aw_err_q;
  logic                  slv_q;
  logic                  dec_q;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic aw_fire;
  logic w_fire;
  logic last_beat;
  logic in_range;
  logic aw_slv;
  logic aw_dec;

  // Readies come straight from the state register only.
  assign bus.awready = sig_reset && (state == IDLE);
  assign bus.wready  = (state == DATA);
  assign bus.bvalid  = (state == RESP);

  assign aw_fire   = bus.awvalid && bus.awready;
  assign w_fire    = bus.wvalid && bus.wready;
  assign last_beat = (cnt_q == len_q);
  assign in_range  = (idx_q < IW'(MEM_WORDS));

  assign aw_slv = (bus.awsize != 3'(LSB))
               || bus.awburst[1];
  assign aw_dec = (bus.awaddr >=
                   ADDR_WIDTH'(MEM_WORDS * STRB_WIDTH));

  assign bus.bid = (state == RESP) ? id_q : '0;

  always_comb begin
    bus.bresp = RESP_OKAY;
    if (state == RESP) begin
      if (dec_q)
        bus.bresp = RESP_DECERR;
      else if (slv_q)
        bus.bresp = RESP_SLVERR;
    end
  end

  always_ff @(posedge sig_clock or negedge sig_reset) begin
    if (!sig_reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (aw_fire) state_nx = DATA;
      DATA: if (w_fire && last_beat) state_nx = RESP;
      RESP: if (bus.bready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A size/burst error from AW blocks every write of the burst;
  // a wlast mismatch is only reported, the beat still lands.
  always_ff @(posedge sig_clock or negedge sig_reset) begin
    if (!sig_reset) begin
      id_q     <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      burst_q  <= '0;
      aw_err_q <= 1'b0;
      slv_q    <= 1'b0;
      dec_q    <= 1'b0;
      for (int i = 0; i < MEM_WORDS; i++)
        mem[i] <= '0;
    end else begin
      if (aw_fire) begin
        id_q     <= bus.awid;
        idx_q    <= bus.awaddr[ADDR_WIDTH-1:LSB];
        len_q    <= bus.awlen;
        burst_q  <= bus.awburst;
        cnt_q    <= '0;
        aw_err_q <= aw_slv;
        slv_q    <= aw_slv;
        dec_q    <= aw_dec;
      end
      if (w_fire) begin
        if (!aw_err_q && in_range) begin
          for (int k = 0; k < STRB_WIDTH; k++)
            if (bus.wstrb[k])
              mem[idx_q[MW-1:0]][8*k +: 8] <=
                bus.wdata[8*k +: 8];
        end
        if (!in_range)
          dec_q <= 1'b1;
        if (bus.wlast != last_beat)
          slv_q <= 1'b1;
        if (burst_q != BURST_FIXED)
          idx_q <= idx_q + 1'b1;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign dbg_data = mem[dbg_idx];

endmodule

// File: tb/tb_axi_wr_slave_mem.sv
// Directed bench for axi_wr_slave_mem: timing, strobes,
// range overrun, FIXED/wlast, bad AW, reset mid-burst.
module tb_axi_wr_slave_mem;
  logic        sig_clock = 1'b0;
  logic        sig_reset = 1'b0;
  logic [3:0]  dbg_idx   = '0;
  logic [63:0] dbg_data;

  int checks = 0;
  int errors = 0;

  axi_wr_slave_mem_if axi ();

  axi_wr_slave_mem dut (
    .sig_clock (sig_clock),
    .sig_reset (sig_reset),
    .bus       (axi),
    .dbg_idx   (dbg_idx),
    .dbg_data  (dbg_data)
  );

  always #5 sig_clock = ~sig_clock;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sig_clock);
    #1;
  endtask

  task automatic send_aw(input logic [31:0] id,
                         input logic [31:0] addr,
                         input logic [7:0]  len,
                         input logic [2:0]  size,
                         input logic [1:0]  burst);
    int n = 0;
    axi.awid    = id;
    axi.awaddr  = addr;
    axi.awlen   = len;
    axi.awsize  = size;
    axi.awburst = burst;
    axi.awvalid = 1'b1;
    while (!axi.awready && n < 50) begin
      tick();
      n++;
    end
    check("awready", 64'(axi.awready), 64'd1);
    tick();
    axi.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] data,
                        input logic [7:0]  strb,
                        input logic        last);
    int n = 0;
    axi.wdata  = data;
    axi.wstrb  = strb;
    axi.wlast  = last;
    axi.wvalid = 1'b1;
    while (!axi.wready && n < 50) begin
      tick();
      n++;
    end
    check("wready", 64'(axi.wready), 64'd1);
    tick();
    axi.wvalid = 1'b0;
  endtask

  task automatic mem_is(input string tag,
                        input int idx,
                        input logic [63:0] exp);
    dbg_idx = 4'(idx);
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic get_b(input string tag,
                       input logic [31:0] id,
                       input logic [1:0]  resp,
                       input int          hold);
    int n = 0;
    while (!axi.bvalid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_bvalid"}, 64'(axi.bvalid), 64'd1);
    check({tag, "_bid"}, 64'(axi.bid), 64'(id));
    check({tag, "_bresp"}, 64'(axi.bresp), 64'(resp));
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, "_hold_v"}, 64'(axi.bvalid), 64'd1);
      check({tag, "_hold_id"}, 64'(axi.bid), 64'(id));
      check({tag, "_hold_r"}, 64'(axi.bresp), 64'(resp));
    end
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    check({tag, "_bdone"}, 64'(axi.bvalid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    axi.awid    = '0;
    axi.awaddr  = '0;
    axi.awlen   = '0;
    axi.awsize  = '0;
    axi.awburst = '0;
    axi.awvalid = 1'b0;
    axi.wdata   = '0;
    axi.wstrb   = '0;
    axi.wlast   = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;

    // reset state
    repeat (3) tick();
    check("rst_awready", 64'(axi.awready), 64'd0);
    check("rst_wready", 64'(axi.wready), 64'd0);
    check("rst_bvalid", 64'(axi.bvalid), 64'd0);
    check("rst_bid", 64'(axi.bid), 64'd0);
    check("rst_bresp", 64'(axi.bresp), 64'd0);
    mem_is("rst_mem2", 2, 64'd0);
    sig_reset = 1'b1;
    #1;
    check("rst_rel_awready", 64'(axi.awready), 64'd1);
    tick();

    // single beat with cycle-exact timing
    send_aw(5, 32'h10, 8'd0, 3'd3, 2'b01);
    check("t1_aw_n1", 64'(axi.awready), 64'd0);
    check("t1_bv_n1", 64'(axi.bvalid), 64'd0);
    send_w(64'h1122334455667788, 8'hFF, 1'b1);
    check("t1_bv_n2", 64'(axi.bvalid), 64'd1);
    check("t1_aw_n2", 64'(axi.awready), 64'd0);
    check("t1_bid", 64'(axi.bid), 64'd5);
    check("t1_bresp", 64'(axi.bresp), 64'd0);
    mem_is("t1_mem2", 2, 64'h1122334455667788);
    axi.bready = 1'b1;
    tick();
    axi.bready = 1'b0;
    check("t1_aw_n3", 64'(axi.awready), 64'd1);
    check("t1_bv_n3", 64'(axi.bvalid), 64'd0);

    // strobe merge
    send_aw(6, 32'h10, 8'd0, 3'd3, 2'b01);
    send_w(64'hAAAAAAAABBBBBBBB, 8'h0F, 1'b1);
    get_b("merge", 6, 2'b00, 0);
    mem_is("merge_mem2", 2, 64'h11223344BBBBBBBB);

    // INCR overrun past the last word, B held 3 cycles
    send_aw(7, 32'h70, 8'd3, 3'd3, 2'b01);
    send_w(64'd1, 8'hFF, 1'b0);
    send_w(64'd2, 8'hFF, 1'b0);
    send_w(64'd3, 8'hFF, 1'b0);
    send_w(64'd4, 8'hFF, 1'b1);
    get_b("ovr", 7, 2'b11, 3);
    mem_is("ovr_mem14", 14, 64'd1);
    mem_is("ovr_mem15", 15, 64'd2);
    mem_is("ovr_mem0", 0, 64'd0);
    mem_is("ovr_mem1", 1, 64'd0);

    // FIXED burst, wlast correct
    send_aw(8, 32'h08, 8'd2, 3'd3, 2'b00);
    send_w(64'd1, 8'hFF, 1'b0);
    send_w(64'd2, 8'hFF, 1'b0);
    send_w(64'd3, 8'hFF, 1'b1);
    get_b("fix", 8, 2'b00, 0);
    mem_is("fix_mem1", 1, 64'd3);
    mem_is("fix_mem2", 2, 64'h11223344BBBBBBBB);

    // FIXED burst, wlast on the first beat: still 3 beats
    send_aw(9, 32'h08, 8'd2, 3'd3, 2'b00);
    send_w(64'd7, 8'hFF, 1'b1);
    send_w(64'd8, 8'hFF, 1'b0);
    send_w(64'd9, 8'hFF, 1'b0);
    get_b("wlast", 9, 2'b10, 0);
    mem_is("wlast_mem1", 1, 64'd9);

    // bad size: writes suppressed
    send_aw(10, 32'h20, 8'd1, 3'd2, 2'b01);
    send_w(64'hDEADBEEFDEADBEEF, 8'hFF, 1'b0);
    send_w(64'hDEADBEEFDEADBEEF, 8'hFF, 1'b1);
    get_b("size", 10, 2'b10, 0);
    mem_is("size_mem4", 4, 64'd0);
    mem_is("size_mem5", 5, 64'd0);

    // reserved burst type: writes suppressed
    send_aw(11, 32'h20, 8'd1, 3'd3, 2'b11);
    send_w(64'hCAFEF00DCAFEF00D, 8'hFF, 1'b0);
    send_w(64'hCAFEF00DCAFEF00D, 8'hFF, 1'b1);
    get_b("burst", 11, 2'b10, 0);
    mem_is("burst_mem4", 4, 64'd0);
    mem_is("burst_mem5", 5, 64'd0);

    // reset mid-burst
    send_aw(12, 32'h30, 8'd3, 3'd3, 2'b01);
    send_w(64'h0123456789ABCDEF, 8'hFF, 1'b0);
    mem_is("mid_mem6_pre", 6, 64'h0123456789ABCDEF);
    sig_reset = 1'b0;
    #1;
    check("mid_awready", 64'(axi.awready), 64'd0);
    check("mid_wready", 64'(axi.wready), 64'd0);
    check("mid_bvalid", 64'(axi.bvalid), 64'd0);
    check("mid_bid", 64'(axi.bid), 64'd0);
    check("mid_bresp", 64'(axi.bresp), 64'd0);
    mem_is("mid_mem6", 6, 64'd0);
    mem_is("mid_mem1", 1, 64'd0);
    mem_is("mid_mem2", 2, 64'd0);
    mem_is("mid_mem14", 14, 64'd0);
    tick();
    sig_reset = 1'b1;
    #1;
    check("mid_rel_awready", 64'(axi.awready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_no_b", 64'(axi.bvalid), 64'd0);
    end

    send_aw(13, 32'h18, 8'd0, 3'd3, 2'b01);
    send_w(64'h5555AAAA5555AAAA, 8'hFF, 1'b1);
    get_b("post", 13, 2'b00, 0);
    mem_is("post_mem3", 3, 64'h5555AAAA5555AAAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_wr_slave_mem.md
# axi_wr_slave_mem

AXI4 write-channel responder: accepts one write burst at a time on AW/W, stores beats into a small internal word memory honouring byte strobes, and returns a single B response per burst. It is the slave-side counterpart to the verification environment's write master and serves as the DUT target for write-path sequences. A combinational debug port exposes memory contents to the scoreboard.

## Interface

- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 64, data width (power of two, ≥16)
- ID_WIDTH, 32, transaction ID width
- STRB_WIDTH, DATA_WIDTH/8, strobe width
- MEM_WORDS, 16, memory depth in DATA_WIDTH words (power of two)

- sig_clock  in  1  clock; all logic on rising edge
- sig_reset  in  1  asynchronous, active-low reset
- awid  in  ID_WIDTH  write address ID
- awaddr  in  ADDR_WIDTH  byte start address
- awlen  in  8  beats minus one
- awsize  in  3  bytes per beat, log2
- awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- awvalid  in  1  address valid
- awready  out  1  address ready
- wdata  in  DATA_WIDTH  write data
- wstrb  in  STRB_WIDTH  byte enables
- wlast  in  1  last beat marker
- wvalid  in  1  data valid
- wready  out  1  data ready
- bid  out  ID_WIDTH  response ID
- bresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
- bvalid  out  1  response valid
- bready  in  1  response ready
- dbg_idx  in  $clog2(MEM_WORDS)  debug word index
- dbg_data  out  DATA_WIDTH  mem[dbg_idx], combinational

## Operation

- FSM states IDLE, DATA, RESP; reset state IDLE.
- IDLE: awready=1. On awvalid&awready latch awid, word index = awaddr>>log2(STRB_WIDTH), awlen, awburst; beat count=0; error flags from AW: SLVERR if awsize≠log2(STRB_WIDTH) or awburst∈{10,11}; DECERR if awaddr ≥ MEM_WORDS*STRB_WIDTH. Go DATA.
- DATA: wready=1. Each wvalid&wready is one beat: if no error latched and word index in range, mem[idx] byte k ← wdata byte k where wstrb[k]=1. INCR: idx+1 after each beat; FIXED: idx unchanged. Beat whose idx ≥ MEM_WORDS is dropped and sets DECERR. Burst ends on beat count==awlen (count-based, wlast not used for termination); wlast≠(count==awlen) on any beat sets SLVERR (beat still written). Final beat → RESP.
- RESP: bvalid=1, bid=latched awid, bresp = DECERR if set, else SLVERR if set, else OKAY. On bready → IDLE.
- SLVERR from AW phase suppresses all writes of that burst; wlast-mismatch SLVERR does not.
- W beats while not in DATA, AW while not in IDLE: not accepted (ready low).
- awlock/awcache/awprot/awqos/awregion/wid not connected.

## Timing

- Reset (sig_reset=0): state IDLE, all outputs 0 (awready, wready, bvalid, bid, bresp), memory cleared to 0, counters 0. awready rises combinationally when sig_reset=1 and state=IDLE.
- Reset mid-burst: burst discarded, no B issued, memory cleared.
- awready/wready/bvalid decode directly from state register; no combinational path from any valid to any ready.
- Minimum single-beat burst: AW handshake cycle N, W cycle N+1, bvalid from N+2; with bready=1 at N+2, awready high at N+3.
- Burst of L+1 beats with wvalid held high: bvalid earliest N+L+2.
- bvalid, bid, bresp stable while bready=0.
- dbg_data reflects a write on the cycle after the beat handshake.

## Test plan

- Single beat: AW id=5 addr=0x10 len=0 size=3 INCR, W 0x1122334455667788 strb=0xFF last=1 → mem[2]=0x1122334455667788; bvalid 2 cycles after AW handshake, bid=5, bresp=00; awready low N+1..N+2.
- Strobe merge: then W 0xAAAAAAAABBBBBBBB strb=0x0F to addr 0x10 → mem[2]=0x11223344BBBBBBBB, OKAY.
- Range overrun: INCR len=3 addr=0x70 data 1,2,3,4 → mem[14]=1, mem[15]=2, beats 3–4 dropped, bresp=11; bready low 3 cycles → bvalid/bid/bresp held.
- FIXED and wlast error: FIXED len=2 addr=0x08 data 1,2,3 wlast correct → mem[1]=3, OKAY; repeat with wlast on beat 1 → 3 beats accepted, mem[1]=3, bresp=10.
- Bad size/burst: size=2 or burst=11, len=1 → 2 beats accepted, memory unchanged, bresp=10.
- Reset mid-burst: INCR len=3, assert sig_reset after beat 1 → all outputs 0, mem all 0, no B; next single-beat write completes OKAY.
